// File: rtl/ifu_pc_gen_if.sv
// Fetch-PC generator bundle: BPU request/response, I-cache request, backend control.
// master = the PC generator, slave = its environment (BPU, I-cache, backend).
interface ifu_pc_gen_if #(
  parameter int unsigned PLEN      = 32,
  parameter int unsigned FTQ_DEPTH = 4
);
  logic [PLEN-1:0]                bpu_pc_o;
  logic                           bpu_valid_o;
  logic                           bpu_ready_i;
  logic [PLEN-1:0]                bpu_npc_i;
  logic                           icache_req_valid_o;
  logic [PLEN-1:0]                icache_req_pc_o;
  logic                           icache_req_ready_i;
  logic                           redirect_valid_i;
  logic [PLEN-1:0]                redirect_pc_i;
  logic                           fetch_stall_i;
  logic [$clog2(FTQ_DEPTH):0]     ftq_count_o;

  modport master (
    output bpu_pc_o, bpu_valid_o, icache_req_valid_o, icache_req_pc_o, ftq_count_o,
    input  bpu_ready_i, bpu_npc_i, icache_req_ready_i, redirect_valid_i, redirect_pc_i,
           fetch_stall_i
  );

  modport slave (
    input  bpu_pc_o, bpu_valid_o, icache_req_valid_o, icache_req_pc_o, ftq_count_o,
    output bpu_ready_i, bpu_npc_i, icache_req_ready_i, redirect_valid_i, redirect_pc_i,
           fetch_stall_i
  );
endinterface

// File: rtl/ifu_pc_gen.sv
// Fetch-PC generator with a small fetch target queue feeding the I-cache.
// Holds the current block PC for the BPU and queues each accepted PC for fetch.
module ifu_pc_gen #(
  parameter int unsigned     PLEN         = 32,
  parameter logic [PLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter int unsigned     FTQ_DEPTH    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ifu_pc_gen_if.master  bus
);

  localparam int unsigned      PTR_W   = $clog2(FTQ_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FTQ_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [PLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PLEN-1:0]  fifo_q [FTQ_DEPTH];

  logic ic_valid;
  logic bpu_valid;
  logic pop;
  logic push;
  logic can_push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect always wins and forces a one-cycle bubble, even from BOOT or FLUSH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (bus.redirect_valid_i) begin
      state_d = FLUSH;
    end
  end

  // pop feeds can_push, so icache_req_ready_i reaches bpu_valid_o combinationally.
  always_comb begin
    ic_valid  = (count_q != '0) & ~bus.redirect_valid_i & (state_q != FLUSH);
    pop       = ic_valid & bus.icache_req_ready_i;
    can_push  = (count_q < DEPTH_C) | pop;
    bpu_valid = (state_q == RUN) & ~bus.fetch_stall_i & ~bus.redirect_valid_i & can_push;
    push      = bpu_valid & bus.bpu_ready_i;
  end

  assign bus.bpu_pc_o           = pc_q;
  assign bus.bpu_valid_o        = bpu_valid;
  assign bus.icache_req_valid_o = ic_valid;
  assign bus.icache_req_pc_o    = ic_valid ? fifo_q[head_q] : '0;
  assign bus.ftq_count_o        = count_q;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.redirect_valid_i) begin
      pc_d    = bus.redirect_pc_i;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = bus.bpu_npc_i;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_VECTOR;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage is pure data: never reset, the empty gate hides stale entries.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[tail_q] <= pc_q;
    end
  end

endmodule

// File: doc/ifu_pc_gen.md
Name: ifu_pc_gen

Overview:
- Fetch-PC generator and fetch target queue in the IFU, directly upstream of the BPU.
- Holds the current fetch-block PC and presents it to the BPU, which returns the next PC. On each accepted prediction, the current PC is latched into a small FIFO and the predicted next PC is adopted.
- The FIFO head drives the I-cache fetch request. A backend redirect flushes the queue and reloads the PC.

Parameters:
- PLEN, 32, physical/virtual PC width in bits.
- RESET_VECTOR, 32'h8000_0000, first fetch PC after reset.
- FTQ_DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- bpu_pc_o  output  PLEN  current fetch-block PC sent to BPU.
- bpu_valid_o  output  1  bpu_pc_o is a request.
- bpu_ready_i  input  1  BPU accepts request.
- bpu_npc_i  input  PLEN  predicted next PC; sampled on BPU fire.
- icache_req_valid_o  output  1  FIFO head valid.
- icache_req_pc_o  output  PLEN  FIFO head PC.
- icache_req_ready_i  input  1  I-cache accepts head.
- redirect_valid_i  input  1  backend redirect / flush.
- redirect_pc_i  input  PLEN  redirect target.
- fetch_stall_i  input  1  inhibit new BPU requests (fence, WFI).
- ftq_count_o  output  $clog2(FTQ_DEPTH)+1  current occupancy.

Behaviour:
- Reset values:
  - state = BOOT, pc_q = RESET_VECTOR.
  - head/tail pointers = 0, count = 0.
  - All valid outputs = 0; icache_req_pc_o = 0 (RAM-independent, gated to 0 when empty).
  - ftq_count_o = 0.
- States:
  - BOOT: one bubble cycle after reset release, no requests; -> RUN.
  - RUN: normal operation.
  - FLUSH: one bubble cycle after a redirect; -> RUN.
- Definitions:
  - pop = icache_req_valid_o & icache_req_ready_i.
  - can_push = (count < FTQ_DEPTH) | pop.
  - This intentionally gives a combinational path from icache_req_ready_i to bpu_valid_o.
- bpu_valid_o = (state==RUN) & ~fetch_stall_i & ~redirect_valid_i & can_push.
- bpu_pc_o = pc_q in all states.
- BPU fire = bpu_valid_o & bpu_ready_i. On fire:
  - FIFO[tail] <= pc_q; tail++ (wraps modulo FTQ_DEPTH).
  - pc_q <= bpu_npc_i.
  - Latency from fire to head visibility is 1 cycle when the queue was empty.
- icache_req_valid_o = (count != 0) & ~redirect_valid_i & (state != FLUSH).
- icache_req_pc_o = FIFO[head] when valid, else 0. On pop: head++ (wraps).
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
  - Simultaneous push+pop when full is legal; count stays FTQ_DEPTH.
- Redirect (any state, highest priority):
  - Same cycle: no push, no pop.
  - Next edge: head = tail = 0, count = 0, pc_q <= redirect_pc_i, state -> FLUSH.
  - Redirect while already in FLUSH: reload again and stay in FLUSH.
  - Redirect in BOOT: honoured; goes to FLUSH.
- fetch_stall_i:
  - Blocks pushes only; pc_q holds.
  - Queued entries continue to drain to the I-cache.
- Handshake rules:
  - icache_req_pc_o is stable while icache_req_valid_o=1 and not popped, except when a redirect drops valid.
  - bpu_pc_o is stable while bpu_valid_o=1 and not fired.
- Redirect PC is not realigned; the block carries PCs verbatim.
- Async reset mid-operation returns everything to reset values immediately; queued entries are discarded.

Test Plan:
- Reset release with bpu_ready_i=1, icache_req_ready_i=0, BPU returning pc+16:
  - Cycle 0 (BOOT): no valids.
  - Then pushes 8000_0000, 8000_0010, 8000_0020, 8000_0030.
  - ftq_count_o=4, bpu_valid_o=0, pc_q=8000_0040.
- From full, assert icache_req_ready_i=1 continuously:
  - One push and one pop every cycle, count holds 4.
  - Heads in order 8000_0000, 8000_0010, …; pointers wrap cleanly past entry 3.
- Queue count=3, redirect_valid_i=1 with redirect_pc_i=8000_1004:
  - That cycle: icache_req_valid_o=0, bpu_valid_o=0.
  - Next cycle: FLUSH, count=0.
  - Following cycle: bpu_pc_o=8000_1004, bpu_valid_o=1.
- Back-to-back redirects to 8000_2000 then 8000_3000:
  - Stays in FLUSH; first BPU request after the bubble is 8000_3000.
- fetch_stall_i=1 with count=2, icache_req_ready_i=1:
  - Two pops (heads in order), no pushes, count reaches 0, pc_q unchanged.
  - Deassert stall -> push resumes at the held pc_q.
- Assert rst_i asynchronously mid-stream with count=2:
  - Outputs drop immediately to 0, count=0.
  - After release: BOOT bubble, then first request at 8000_0000.
